// File: rtl/irq_fetch_master_pkg.sv
// Shared definitions for the interruptus bus initiator: controller register map,
// sequencing FSM encodings and bus-cycle kinds.
package irq_fetch_master_pkg;

    localparam logic [13:0] STATUS_ADDR   = 14'h2000;
    localparam logic [13:0] TIMER_LO_ADDR = 14'h2002;
    localparam logic [13:0] TIMER_HI_ADDR = 14'h2004;

    // Encodings are shared with the interruptus controller and its bench; keep the order.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_RD_HI = 3'd2,
        ST_RD_LO = 3'd3,
        ST_HOST  = 3'd4,
        ST_REC   = 3'd5
    } fsm_state_t;

    typedef enum logic [1:0] {
        CYC_ACK = 2'd0,
        CYC_RD  = 2'd1,
        CYC_WR  = 2'd2
    } cyc_kind_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_LOW  = 2'd1,
        PH_REC  = 2'd2
    } bus_phase_t;

endpackage

// File: rtl/irq_bus_cycle.sv
// Generic strobe/recovery timer: runs one ack, read or write cycle on the controller bus
// and owns the strobes, the address register and the data_bus tri-state.
module irq_bus_cycle
    import irq_fetch_master_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  cyc_kind_t   kind,
    input  logic [13:0] addr,
    input  logic [15:0] wdata,
    output logic        sample,
    output logic        done,
    output logic        int_ack_n,
    output logic        read_n,
    output logic        write_n,
    output logic [13:0] addr_bus,
    inout  wire  [15:0] data_bus
);

    localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    bus_phase_t        phase;
    cyc_kind_t         kind_q;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       wdata_q;

    // A new cycle may be launched from recovery so back-to-back cycles need no idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= PH_IDLE;
            kind_q   <= CYC_ACK;
            cnt      <= '0;
            wdata_q  <= '0;
            addr_bus <= '0;
        end else if (start && (phase != PH_LOW)) begin
            phase   <= PH_LOW;
            kind_q  <= kind;
            cnt     <= CNT_W'(STROBE_CYCLES - 1);
            wdata_q <= wdata;
            if (kind != CYC_ACK) begin
                addr_bus <= addr;
            end
        end else begin
            case (phase)
                PH_LOW: begin
                    if (cnt == '0) begin
                        phase <= PH_REC;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                PH_REC:  phase <= PH_IDLE;
                default: phase <= PH_IDLE;
            endcase
        end
    end

    assign sample    = (phase == PH_LOW) && (cnt == '0);
    assign done      = (phase == PH_REC);
    assign int_ack_n = !((phase == PH_LOW) && (kind_q == CYC_ACK));
    assign read_n    = !((phase == PH_LOW) && (kind_q == CYC_RD));
    assign write_n   = !((phase == PH_LOW) && (kind_q == CYC_WR));

    assign data_bus = ((phase != PH_IDLE) && (kind_q == CYC_WR)) ? wdata_q : 16'hzzzz;

endmodule

// File: rtl/irq_fetch_master.sv
// Bus-side initiator for the interruptus controller: acknowledges interrupts, timestamps the
// vector from TIMER_HI/TIMER_LO, and serves single host cycles between services.
//
//   state  | meaning
//   IDLE   | waiting; interrupt (holding reg empty) beats host request
//   ACK    | int_ack_n low, vector captured on the last low cycle
//   RD_HI  | reading TIMER_HI
//   RD_LO  | reading TIMER_LO
//   HOST   | single host read or write strobe
//   REC    | recovery, all strobes high; prev_q picks what follows
module irq_fetch_master
    import irq_fetch_master_pkg::*;
#(
    parameter int          STROBE_CYCLES = 2,
    parameter logic [13:0] TIMER_LO_ADDR = irq_fetch_master_pkg::TIMER_LO_ADDR,
    parameter logic [13:0] TIMER_HI_ADDR = irq_fetch_master_pkg::TIMER_HI_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_n,
    output logic        int_ack_n,
    output logic        read_n,
    output logic        write_n,
    output logic [13:0] addr_bus,
    inout  wire  [15:0] data_bus,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [13:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [15:0] evt_vector,
    output logic [31:0] evt_time
);

    fsm_state_t  state_q, state_d, prev_q;
    logic        cyc_start, cyc_sample, cyc_done;
    cyc_kind_t   cyc_kind;
    logic [13:0] cyc_addr;
    logic [15:0] vec_q, hi_q, lo_q;

    irq_bus_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus_cycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (cyc_start),
        .kind     (cyc_kind),
        .addr     (cyc_addr),
        .wdata    (host_wdata),
        .sample   (cyc_sample),
        .done     (cyc_done),
        .int_ack_n(int_ack_n),
        .read_n   (read_n),
        .write_n  (write_n),
        .addr_bus (addr_bus),
        .data_bus (data_bus)
    );

    always_comb begin
        state_d   = state_q;
        cyc_start = 1'b0;
        cyc_kind  = CYC_ACK;
        cyc_addr  = host_addr;
        case (state_q)
            ST_IDLE: begin
                if (!int_n && !evt_valid) begin
                    state_d   = ST_ACK;
                    cyc_start = 1'b1;
                end else if (host_req && !host_ack) begin
                    // host_ack still high means this request was just completed
                    state_d   = ST_HOST;
                    cyc_start = 1'b1;
                    cyc_kind  = host_we ? CYC_WR : CYC_RD;
                end
            end
            ST_ACK, ST_RD_HI, ST_RD_LO, ST_HOST: begin
                if (cyc_sample) begin
                    state_d = ST_REC;
                end
            end
            ST_REC: begin
                if (cyc_done) begin
                    case (prev_q)
                        ST_ACK: begin
                            state_d   = ST_RD_HI;
                            cyc_start = 1'b1;
                            cyc_kind  = CYC_RD;
                            cyc_addr  = TIMER_HI_ADDR;
                        end
                        ST_RD_HI: begin
                            state_d   = ST_RD_LO;
                            cyc_start = 1'b1;
                            cyc_kind  = CYC_RD;
                            cyc_addr  = TIMER_LO_ADDR;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            prev_q     <= ST_IDLE;
            vec_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
            evt_valid  <= 1'b0;
            evt_vector <= '0;
            evt_time   <= '0;
        end else begin
            state_q  <= state_d;
            host_ack <= (state_q == ST_REC) && (prev_q == ST_HOST);
            if (cyc_sample && (state_q != ST_REC) && (state_q != ST_IDLE)) begin
                prev_q <= state_q;
                case (state_q)
                    ST_ACK:   vec_q <= data_bus;
                    ST_RD_HI: hi_q  <= data_bus;
                    ST_RD_LO: lo_q  <= data_bus;
                    default: begin
                        if (!host_we) begin
                            host_rdata <= data_bus;
                        end
                    end
                endcase
            end
            // The holding register is always empty while a service runs, so load never collides.
            if ((state_q == ST_REC) && (prev_q == ST_RD_LO)) begin
                evt_valid  <= 1'b1;
                evt_vector <= vec_q;
                evt_time   <= {hi_q, lo_q};
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irq_fetch_master.sv
// Directed bench for irq_fetch_master: a cycle table for one interrupt service plus
// hand-written sequences for host cycles, priority and asynchronous reset.
module tb_irq_fetch_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        int_n = 1'b1;
    logic        int_ack_n, read_n, write_n;
    logic [13:0] addr_bus;
    wire  [15:0] data_bus;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [13:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [15:0] evt_vector;
    logic [31:0] evt_time;

    logic        tb_drive = 1'b0;
    logic [15:0] rd_val;

    int tests = 0;
    int fails = 0;

    int ack_cnt = 0, rd_cnt = 0, wr_cnt = 0, hack_cnt = 0, overlap = 0;
    logic [15:0] last_wdata = '0;
    logic [13:0] last_waddr = '0;

    irq_fetch_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .int_n     (int_n),
        .int_ack_n (int_ack_n),
        .read_n    (read_n),
        .write_n   (write_n),
        .addr_bus  (addr_bus),
        .data_bus  (data_bus),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_ack  (host_ack),
        .host_rdata(host_rdata),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_vector(evt_vector),
        .evt_time  (evt_time)
    );

    always #5 clk = ~clk;

    // Controller model: vector on ack, register contents on read.
    always_comb begin
        case (addr_bus)
            14'h2004: rd_val = 16'h0012;
            14'h2002: rd_val = 16'h3456;
            14'h2000: rd_val = 16'h00FE;
            default:  rd_val = 16'h0000;
        endcase
    end

    assign data_bus = tb_drive    ? 16'hA5A5 :
                      !int_ack_n  ? 16'h0001 :
                      !read_n     ? rd_val   : 16'hzzzz;

    always @(negedge clk) begin
        if (!int_ack_n) ack_cnt <= ack_cnt + 1;
        if (!read_n)    rd_cnt  <= rd_cnt + 1;
        if (!write_n) begin
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= data_bus;
            last_waddr <= addr_bus;
        end
        if (host_ack) hack_cnt <= hack_cnt + 1;
        if ((int'(!int_ack_n) + int'(!read_n) + int'(!write_n)) > 1) overlap <= overlap + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return evt_valid == 1'b1;
            1:       return host_ack == 1'b1;
            2:       return read_n == 1'b0;
            3:       return int_ack_n == 1'b0;
            default: return write_n == 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input int max);
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            #1;
            if (cond(sel)) break;
        end
        check(name, 32'(cond(sel)), 32'd1);
    endtask

    typedef struct {
        logic        int_n;
        logic        evt_ready;
        logic        ack_n;
        logic        rd_n;
        logic        wr_n;
        logic [13:0] addr;
        logic        valid;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int a0, r0, w0, h0;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 14'h0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h2004, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h2004, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 14'h2004, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h2002, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h2002, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 14'h2002, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 14'h2002, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 14'h2002, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 14'h2002, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 14'h2002, 1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst int_ack_n", 32'(int_ack_n), 32'd1);
        check("rst read_n", 32'(read_n), 32'd1);
        check("rst write_n", 32'(write_n), 32'd1);
        check("rst addr_bus", 32'(addr_bus), 32'd0);
        check("rst host_ack", 32'(host_ack), 32'd0);
        check("rst host_rdata", 32'(host_rdata), 32'd0);
        check("rst evt_valid", 32'(evt_valid), 32'd0);
        check("rst evt_vector", 32'(evt_vector), 32'd0);
        check("rst evt_time", evt_time, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // One interrupt service, cycle by cycle, then holding-register handshake
        for (int i = 0; i < 13; i++) begin
            int_n     = tbl[i].int_n;
            evt_ready = tbl[i].evt_ready;
            @(posedge clk);
            #1;
            check($sformatf("tbl[%0d] int_ack_n", i), 32'(int_ack_n), 32'(tbl[i].ack_n));
            check($sformatf("tbl[%0d] read_n", i), 32'(read_n), 32'(tbl[i].rd_n));
            check($sformatf("tbl[%0d] write_n", i), 32'(write_n), 32'(tbl[i].wr_n));
            check($sformatf("tbl[%0d] addr_bus", i), 32'(addr_bus), 32'(tbl[i].addr));
            check($sformatf("tbl[%0d] evt_valid", i), 32'(evt_valid), 32'(tbl[i].valid));
        end
        check("evt_vector", 32'(evt_vector), 32'h0001);
        check("evt_time", evt_time, 32'h00123456);

        // Full holding register blocks acks but not host writes
        int_n = 1'b0;
        wait_for("evt fill", 0, 20);
        a0 = ack_cnt; w0 = wr_cnt;
        host_req = 1'b1; host_we = 1'b1; host_addr = 14'h2002; host_wdata = 16'hBEEF;
        wait_for("host_ack write", 1, 20);
        @(posedge clk);
        #1;
        host_req = 1'b0;
        check("host_ack single pulse", 32'(host_ack), 32'd0);
        check("no re-accept write_n", 32'(write_n), 32'd1);
        check("write low cycles", 32'(wr_cnt - w0), 32'd2);
        check("write data", 32'(last_wdata), 32'hBEEF);
        check("write addr", 32'(last_waddr), 32'h2002);
        repeat (5) @(posedge clk);
        #1;
        check("no ack while full", 32'(ack_cnt - a0), 32'd0);
        evt_ready = 1'b1;
        wait_for("ack after ready", 3, 5);
        evt_ready = 1'b0;
        int_n = 1'b1;
        wait_for("evt second", 0, 20);
        check("evt_vector second", 32'(evt_vector), 32'h0001);
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
        check("evt drained", 32'(evt_valid), 32'd0);

        // Interrupt and host request on the same edge: interrupt wins
        r0 = rd_cnt; w0 = wr_cnt;
        int_n = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0010; host_wdata = 16'h1234;
        @(posedge clk);
        #1;
        int_n = 1'b1;
        check("prio int_ack_n", 32'(int_ack_n), 32'd0);
        check("prio write_n", 32'(write_n), 32'd1);
        wait_for("prio evt", 0, 20);
        check("prio no write yet", 32'(wr_cnt - w0), 32'd0);
        check("prio timer reads", 32'(rd_cnt - r0), 32'd4);
        wait_for("prio host_ack", 1, 20);
        host_req = 1'b0;
        check("prio write cycles", 32'(wr_cnt - w0), 32'd2);
        check("prio write data", 32'(last_wdata), 32'h1234);
        check("prio write addr", 32'(last_waddr), 32'h0010);
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;

        // Host read of the status register
        r0 = rd_cnt;
        host_req = 1'b1; host_we = 1'b0; host_addr = 14'h2000;
        wait_for("read host_ack", 1, 20);
        host_req = 1'b0;
        check("host_rdata", 32'(host_rdata), 32'h00FE);
        check("read low cycles", 32'(rd_cnt - r0), 32'd2);
        @(posedge clk);
        #1;
        check("read host_ack pulse", 32'(host_ack), 32'd0);
        check("host_rdata held", 32'(host_rdata), 32'h00FE);

        // Asynchronous reset in the middle of a host write
        h0 = hack_cnt;
        host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0100; host_wdata = 16'hBEEF;
        wait_for("write start", 4, 10);
        #1;
        rst_n = 1'b0;
        tb_drive = 1'b1;
        #1;
        check("arst write_n", 32'(write_n), 32'd1);
        check("arst data_bus released", 32'(data_bus), 32'hA5A5);
        check("arst host_ack", 32'(host_ack), 32'd0);
        tb_drive = 1'b0;
        host_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("arst no host_ack", 32'(hack_cnt - h0), 32'd0);

        // Asynchronous reset during RD_HI, then a fresh service
        int_n = 1'b0;
        wait_for("rd_hi start", 2, 10);
        check("rd_hi addr", 32'(addr_bus), 32'h2004);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst read_n", 32'(read_n), 32'd1);
        check("arst evt_valid", 32'(evt_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_for("fresh ack", 3, 3);
        wait_for("fresh evt", 0, 20);
        check("fresh evt_time", evt_time, 32'h00123456);
        int_n = 1'b1;
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;

        check("one strobe at a time", 32'(overlap), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
